cs_access_seq: RTL

CS_ACCESS_SEQ -- requirements
Module: cs_access_seq

---
 rtl/cs_access_seq_if.sv | 32 +++
 rtl/cs_access_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cs_access_seq_if.sv
// Control-store access sequencer bus: the request/slice handshake and the
// control-store port. The sequencer is the slave; the block driving
// commands (and the control-store model) sits on the master side.
interface cs_access_seq_if;
  logic        RWCS_n;
  logic        OPCLCS_n;
  logic        WRITE;
  logic [11:0] CSA;
  logic        LDSL_n;
  logic        RDSL_n;
  logic [15:0] IDB_IN;
  logic [15:0] IDB_OUT;
  logic [11:0] CS_ADDR;
  logic [63:0] CS_DIN;
  logic [63:0] CS_DOUT;
  logic        CS_OE_n;
  logic        CS_WE_n;
  logic        BUSY;
  logic        DONE;
  logic        OVRUN;
  logic [1:0]  SLPTR;

  modport slave (
    input  RWCS_n, OPCLCS_n, WRITE, CSA, LDSL_n, RDSL_n, IDB_IN, CS_DOUT,
    output IDB_OUT, CS_ADDR, CS_DIN, CS_OE_n, CS_WE_n, BUSY, DONE, OVRUN, SLPTR
  );

  modport master (
    output RWCS_n, OPCLCS_n, WRITE, CSA, LDSL_n, RDSL_n, IDB_IN, CS_DOUT,
    input  IDB_OUT, CS_ADDR, CS_DIN, CS_OE_n, CS_WE_n, BUSY, DONE, OVRUN, SLPTR
  );
endinterface

// File: rtl/cs_access_seq.sv
// Control-store access sequencer.
// A 64-bit data latch is loaded/read 16 bits at a time through a 2-bit slice
// pointer. An RWCS_n request copies the latch into the control store (write)
// or fills the latch from the control store (read) with fixed timing:
//   read : RD_ACC, RD_CAP (CS_OE_n low), FIN
//   write: WR_SETUP, WR_PULSE x2 (CS_WE_n low), WR_HOLD, FIN
// Every strobe and status output is a flop, decoded from the next state so
// it lines up exactly with the state it belongs to.
module cs_access_seq (
  input  logic           CLK,
  input  logic           RESET,
  cs_access_seq_if.slave cs
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ACC   = 3'd1,
    ST_RD_CAP   = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5,
    ST_FIN      = 3'd6
  } state_t;

  // Sequencer state and registered outputs.
  state_t      r_state;
  logic        r_pulse_2nd;   // set during the second WR_PULSE cycle
  logic        r_write;       // direction of the access in flight
  logic [11:0] r_cs_addr;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_busy;
  logic        r_done;

  // Data-path state.
  logic [63:0] r_latch;
  logic [1:0]  r_slptr;
  logic        r_ovrun;

  // Combinational helpers.
  state_t      w_state_nxt;
  logic        w_oe_n_nxt;
  logic        w_we_n_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_busy_st;
  logic        w_accept;
  logic        w_cap_rd;
  logic        w_ovr_set;
  logic [1:0]  w_ptr_base;

  // A request is taken only from IDLE; FIN and the busy states refuse it.
  assign w_accept   = (r_state == ST_IDLE) && !cs.RWCS_n;

  // IDLE and FIN are the only states where the slice port is open.
  assign w_busy_st  = (r_state != ST_IDLE) && (r_state != ST_FIN);

  // The edge that enters FIN after a read is the edge ending the second
  // read cycle: the control-store data is captured there and the pointer
  // rewinds so the host reads the word back from slice 0.
  assign w_cap_rd   = (w_state_nxt == ST_FIN) && (r_state != ST_FIN) && !r_write;

  // Any slice strobe while busy, or a request while busy or in FIN, is
  // dropped and flagged.
  assign w_ovr_set  = (w_busy_st && (!cs.LDSL_n || !cs.RDSL_n || !cs.RWCS_n)) ||
                      ((r_state == ST_FIN) && !cs.RWCS_n);

  // Opening a control-store load rewinds the pointer before any slice
  // operation of the same cycle, so a simultaneous LDSL lands in slice 0.
  assign w_ptr_base = cs.OPCLCS_n ? r_slptr : 2'd0;

  // Next-state decode.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (!cs.RWCS_n) w_state_nxt = cs.WRITE ? ST_WR_SETUP : ST_RD_ACC;
      ST_RD_ACC:   w_state_nxt = ST_RD_CAP;
      ST_RD_CAP:   w_state_nxt = ST_FIN;
      ST_WR_SETUP: w_state_nxt = ST_WR_PULSE;
      ST_WR_PULSE: if (r_pulse_2nd) w_state_nxt = ST_WR_HOLD;
      ST_WR_HOLD:  w_state_nxt = ST_FIN;
      ST_FIN:      w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state, registered below so every output
  // changes on the same edge as the state it describes.
  always_comb begin
    w_oe_n_nxt = 1'b1;
    w_we_n_nxt = 1'b1;
    w_busy_nxt = 1'b1;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      ST_IDLE:     w_busy_nxt = 1'b0;
      ST_RD_ACC:   w_oe_n_nxt = 1'b0;
      ST_RD_CAP:   w_oe_n_nxt = 1'b0;
      ST_WR_SETUP: w_we_n_nxt = 1'b1;
      ST_WR_PULSE: w_we_n_nxt = 1'b0;
      ST_WR_HOLD:  w_we_n_nxt = 1'b1;
      ST_FIN: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
      end
      default:     w_busy_nxt = 1'b0;
    endcase
  end

  // State register, output flops and request capture; reset aborts any
  // access in flight and returns the strobes to their inactive level.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_pulse_2nd <= 1'b0;
      r_write     <= 1'b0;
      r_cs_addr   <= 12'h000;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pulse_2nd <= (r_state == ST_WR_PULSE);
      r_oe_n      <= w_oe_n_nxt;
      r_we_n      <= w_we_n_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      if (w_accept) begin
        r_cs_addr <= cs.CSA;
        r_write   <= cs.WRITE;
      end
    end
  end

  // Data latch, slice pointer and sticky overrun flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the 64-bit latch is plain flops, not a RAM, so it is reset
      // along with the rest; its value is visible on CS_DIN and IDB_OUT.
      r_latch <= 64'h0;
      r_slptr <= 2'd0;
      r_ovrun <= 1'b0;
    end else begin
      // A new overrun in the same cycle as OPCLCS_n wins over the clear.
      if (!cs.OPCLCS_n) r_ovrun <= 1'b0;
      if (w_ovr_set)    r_ovrun <= 1'b1;

      if (w_cap_rd) begin
        r_latch <= cs.CS_DOUT;
        r_slptr <= 2'd0;
      end else if (!w_busy_st) begin
        // LDSL takes precedence over RDSL; either advances the pointer once.
        if (!cs.LDSL_n) begin
          r_latch[{w_ptr_base, 4'h0} +: 16] <= cs.IDB_IN;
          r_slptr                           <= w_ptr_base + 2'd1;
        end else if (!cs.RDSL_n) begin
          r_slptr <= w_ptr_base + 2'd1;
        end else if (!cs.OPCLCS_n) begin
          r_slptr <= 2'd0;
        end
      end else if (!cs.OPCLCS_n) begin
        r_slptr <= 2'd0;
      end
    end
  end

  assign cs.IDB_OUT = r_latch[{r_slptr, 4'h0} +: 16];
  assign cs.CS_ADDR = r_cs_addr;
  assign cs.CS_DIN  = r_latch;
  assign cs.CS_OE_n = r_oe_n;
  assign cs.CS_WE_n = r_we_n;
  assign cs.BUSY    = r_busy;
  assign cs.DONE    = r_done;
  assign cs.OVRUN   = r_ovrun;
  assign cs.SLPTR   = r_slptr;

endmodule
